// File: rtl/strassen_pkg.sv
// Shared types and constants for the Strassen C-combine stage: FSM states,
// c_storage addresses and the per-output product sign table.
package strassen_pkg;

    typedef enum logic [1:0] {
        ACC    = 2'd0,
        WR_TOP = 2'd1,
        WR_BOT = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10
    } op_e;

    localparam int unsigned NUM_PROD = 7;

    localparam logic [1:0] C11_ADDR = 2'd0;
    localparam logic [1:0] C12_ADDR = 2'd1;
    localparam logic [1:0] C21_ADDR = 2'd2;
    localparam logic [1:0] C22_ADDR = 2'd3;

    // Each row packs {M7,...,M1} as 2-bit op codes, M1 in the low bits.
    localparam logic [2*NUM_PROD-1:0] SIGN_C11 = {2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
    localparam logic [2*NUM_PROD-1:0] SIGN_C12 = {2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00};
    localparam logic [2*NUM_PROD-1:0] SIGN_C21 = {2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    localparam logic [2*NUM_PROD-1:0] SIGN_C22 = {2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01};

    localparam logic [2*NUM_PROD-1:0] SIGN_TABLE [4] = '{SIGN_C11, SIGN_C12, SIGN_C21, SIGN_C22};

    function automatic op_e sign_op(input logic [2*NUM_PROD-1:0] row, input logic [2:0] k);
        int unsigned idx;
        if (k == 3'd0 || 32'(k) > NUM_PROD) begin
            return OP_HOLD;
        end
        idx = 32'(k) - 1;
        return op_e'(row[2*idx +: 2]);
    endfunction

endpackage

// File: rtl/c_acc_lane.sv
// One modulo-2^width accumulator lane: clear, add, subtract or hold per cycle.
// The next value is exported so the caller can register a sum in the same edge it completes.
module c_acc_lane
    import strassen_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  op_e              op_i,
    input  logic [width-1:0] m_i,
    output logic [width-1:0] acc_o,
    output logic [width-1:0] acc_nxt_o
);

    logic [width-1:0] acc_q;
    logic [width-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else begin
            case (op_i)
                OP_ADD:  acc_d = acc_q + m_i;
                OP_SUB:  acc_d = acc_q - m_i;
                default: acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o     = acc_q;
    assign acc_nxt_o = acc_d;

endmodule

// File: rtl/c_combiner.sv
// Accumulates Strassen products M1..M7 into C11/C12/C21/C22 and writes them
// to c_storage two words per cycle, then pulses done.
module c_combiner
    import strassen_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic [width-1:0] m_data,
    output logic             we,
    output logic [1:0]       addr1,
    output logic [1:0]       addr2,
    output logic [width-1:0] dIn1,
    output logic [width-1:0] dIn2,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [2:0]       k_q, k_d;
    logic             busy_q, busy_d;
    logic             we_q, we_d;
    logic [1:0]       addr1_q, addr1_d, addr2_q, addr2_d;
    logic [width-1:0] dIn1_q, dIn1_d, dIn2_q, dIn2_d;

    logic             accept;
    logic             clr;
    logic [width-1:0] acc_q   [4];
    logic [width-1:0] acc_nxt [4];

    assign accept = m_valid && (state_q == ACC);
    assign clr    = (state_q == DONE);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        op_e op;
        assign op = accept ? sign_op(SIGN_TABLE[i], k_q) : OP_HOLD;

        c_acc_lane #(
            .width(width)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (clr),
            .op_i     (op),
            .m_i      (m_data),
            .acc_o    (acc_q[i]),
            .acc_nxt_o(acc_nxt[i])
        );
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        busy_d  = busy_q;
        we_d    = 1'b0;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        dIn1_d  = dIn1_q;
        dIn2_d  = dIn2_q;

        case (state_q)
            ACC: begin
                if (accept) begin
                    k_d = k_q + 3'd1;
                    if (k_q == 3'd1) begin
                        busy_d = 1'b1;
                    end
                    // M7 is summed on this same edge, so the top pair comes from the lane next values.
                    if (k_q == 3'(NUM_PROD)) begin
                        state_d = WR_TOP;
                        we_d    = 1'b1;
                        addr1_d = C11_ADDR;
                        dIn1_d  = acc_nxt[0];
                        addr2_d = C12_ADDR;
                        dIn2_d  = acc_nxt[1];
                    end
                end
            end
            WR_TOP: begin
                state_d = WR_BOT;
                we_d    = 1'b1;
                addr1_d = C21_ADDR;
                dIn1_d  = acc_q[2];
                addr2_d = C22_ADDR;
                dIn2_d  = acc_q[3];
            end
            WR_BOT: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = ACC;
                k_d     = 3'd1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            k_q     <= 3'd1;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            dIn1_q  <= '0;
            dIn2_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            dIn1_q  <= dIn1_d;
            dIn2_q  <= dIn2_d;
        end
    end

    assign m_ready = (state_q == ACC);
    assign done    = (state_q == DONE);
    assign busy    = busy_q;
    assign we      = we_q;
    assign addr1   = addr1_q;
    assign addr2   = addr2_q;
    assign dIn1    = dIn1_q;
    assign dIn2    = dIn2_q;

endmodule

// File: tb/tb_c_combiner.sv
// Directed self-checking bench for c_combiner: product beats are driven on the
// falling edge and every output is sampled on the falling edge.
module tb_c_combiner;

    logic        clk;
    logic        rst_n;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        we;
    logic [1:0]  addr1;
    logic [1:0]  addr2;
    logic [31:0] dIn1;
    logic [31:0] dIn2;
    logic        busy;
    logic        done;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    c_combiner #(
        .width(32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .we     (we),
        .addr1  (addr1),
        .addr2  (addr2),
        .dIn1   (dIn1),
        .dIn2   (dIn2),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_ready"}, 32'(m_ready), 32'd1);
        chk({tag, "_we"},      32'(we),      32'd0);
        chk({tag, "_addr1"},   32'(addr1),   32'd0);
        chk({tag, "_addr2"},   32'(addr2),   32'd0);
        chk({tag, "_dIn1"},    dIn1,         32'd0);
        chk({tag, "_dIn2"},    dIn2,         32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
    endtask

    // Called on a falling edge; returns on the falling edge after the beat is accepted.
    task automatic beat(input logic [31:0] d, input int unsigned gap, input logic gap_ready_chk);
        int unsigned t;
        m_valid = 1'b0;
        for (int unsigned g = 0; g < gap; g++) begin
            if (gap_ready_chk) chk("gap_ready", 32'(m_ready), 32'd1);
            @(negedge clk);
        end
        m_valid = 1'b1;
        m_data  = d;
        t = 0;
        while (!m_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!m_ready) chk("accept_timeout", 32'(m_ready), 32'd1);
        @(negedge clk);
        chk("busy_after_beat", 32'(busy), 32'd1);
    endtask

    task automatic run_block(input logic [31:0] v [7], input int unsigned maxgap);
        for (int unsigned i = 0; i < 7; i++) begin
            beat(v[i], (maxgap != 0) ? $urandom_range(maxgap, 0) : 0, i > 0);
        end
    endtask

    // Called right after the M7 beat; walks WR_TOP, WR_BOT, DONE and lands in ACC.
    task automatic end_block(input logic keep_valid, input string tag,
                             input logic [31:0] e11, input logic [31:0] e12,
                             input logic [31:0] e21, input logic [31:0] e22);
        int unsigned lows;
        logic        saw_done;
        lows     = 0;
        saw_done = 1'b0;
        if (!keep_valid) m_valid = 1'b0;
        while (!m_ready && lows < 10) begin
            case (lows)
                0: begin
                    chk({tag, "_top_we"},    32'(we),    32'd1);
                    chk({tag, "_top_addr1"}, 32'(addr1), 32'd0);
                    chk({tag, "_top_dIn1"},  dIn1,       e11);
                    chk({tag, "_top_addr2"}, 32'(addr2), 32'd1);
                    chk({tag, "_top_dIn2"},  dIn2,       e12);
                end
                1: begin
                    chk({tag, "_bot_we"},    32'(we),    32'd1);
                    chk({tag, "_bot_addr1"}, 32'(addr1), 32'd2);
                    chk({tag, "_bot_dIn1"},  dIn1,       e21);
                    chk({tag, "_bot_addr2"}, 32'(addr2), 32'd3);
                    chk({tag, "_bot_dIn2"},  dIn2,       e22);
                end
                2: begin
                    chk({tag, "_done_pulse"}, 32'(done),  32'd1);
                    chk({tag, "_done_we"},    32'(we),    32'd0);
                    chk({tag, "_done_busy"},  32'(busy),  32'd1);
                    chk({tag, "_done_hold"},  dIn2,       e22);
                end
                default: ;
            endcase
            if (done) saw_done = 1'b1;
            lows++;
            @(negedge clk);
        end
        chk({tag, "_saw_done"},   32'(saw_done), 32'd1);
        chk({tag, "_ready_lows"}, lows,          32'd3);
        chk({tag, "_post_busy"},  32'(busy),     32'd0);
        chk({tag, "_post_done"},  32'(done),     32'd0);
    endtask

    logic [31:0] blk [7];

    initial begin
        rst_n   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        blk = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        run_block(blk, 0);
        end_block(1'b0, "basic", 32'd7, 32'd8, 32'd6, 32'd8);

        blk = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};
        run_block(blk, 0);
        end_block(1'b0, "neg", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);

        blk = '{32'h7FFF_FFFF, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
        run_block(blk, 0);
        end_block(1'b0, "wrap", 32'h8000_0000, 32'd0, 32'd1, 32'h7FFF_FFFF);

        blk = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        run_block(blk, 5);
        end_block(1'b0, "gaps", 32'd7, 32'd8, 32'd6, 32'd8);

        beat(32'd1, 0, 1'b0);
        beat(32'd2, 0, 1'b1);
        beat(32'd3, 0, 1'b1);
        rst_n   = 1'b0;
        m_valid = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(blk, 0);
        end_block(1'b0, "postrst", 32'd7, 32'd8, 32'd6, 32'd8);

        run_block(blk, 0);
        end_block(1'b1, "b2b_a", 32'd7, 32'd8, 32'd6, 32'd8);
        chk("b2b_ready_resume", 32'(m_ready), 32'd1);
        blk = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
        run_block(blk, 0);
        end_block(1'b0, "b2b_b", 32'd4, 32'd4, 32'd4, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
